// File: rtl/sprite_line_scheduler.sv
// sprite_line_scheduler: per-scanline sprite ROM sequencer that fills the back line buffer
module sprite_line_scheduler #(
  parameter int         N_OBJ       = 7,
  parameter int         SPR_W       = 32,
  parameter int         SPR_H       = 32,
  parameter int         H_ACTIVE    = 640,
  parameter int         CAR_BASE    = 0,
  parameter int         PLAYER_BASE = 1024,
  parameter logic [8:0] TRANSP      = 9'h001
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  line_start,
  input  logic [9:0]            line_y,
  input  logic [N_OBJ*10-1:0]   obj_x,
  input  logic [N_OBJ*10-1:0]   obj_y,
  input  logic [N_OBJ-1:0]      obj_en,
  output logic [10:0]           spr_addr,
  input  logic [8:0]            spr_data,
  output logic                  lb_clear,
  output logic                  lb_we,
  output logic [9:0]            lb_addr,
  output logic [8:0]            lb_data,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun,
  input  logic                  overrun_clr
);
  localparam int IW = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;
  localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;

  typedef enum logic [2:0] {IDLE, SCAN, FETCH, DRAIN, DONE} state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [RW-1:0]       row_q, row_d;
  logic [CW-1:0]       col_q, col_d;
  logic [CW-1:0]       colw_q, colw_d;
  logic                pend_q, pend_d;
  logic                clear_q, clear_d;
  logic                overrun_q, overrun_d;
  logic [9:0]          y_q, y_d;
  logic [N_OBJ*10-1:0] ox_q, ox_d, oy_q, oy_d;
  logic [N_OBJ-1:0]    en_q, en_d;

  logic [9:0]  ox_cur, oy_cur;
  logic [10:0] y_ext, oy_ext, px;
  logic        hit, last;

  // Current object's shadowed position; compares are 11 bits so oy+SPR_H never wraps
  always_comb begin
    ox_cur = ox_q[idx_q*10 +: 10];
    oy_cur = oy_q[idx_q*10 +: 10];
    y_ext  = {1'b0, y_q};
    oy_ext = {1'b0, oy_cur};
    hit    = en_q[idx_q] && (y_ext >= oy_ext) && (y_ext < oy_ext + 11'(SPR_H));
    last   = idx_q == IW'(N_OBJ - 1);
    px     = {1'b0, ox_cur} + {{(11 - CW){1'b0}}, colw_q};
  end

  // Outputs decoded from state and the one-deep write pipeline (data returns one cycle after its address)
  always_comb begin
    busy     = (state_q == SCAN) || (state_q == FETCH) || (state_q == DRAIN);
    done     = state_q == DONE;
    lb_clear = clear_q;
    overrun  = overrun_q;
    spr_addr = (state_q == FETCH) ?
               (last ? 11'(PLAYER_BASE) : 11'(CAR_BASE)) + 11'(row_q) * 11'(SPR_W) + 11'(col_q) : '0;
    lb_we    = pend_q && (spr_data != TRANSP) && (px < 11'(H_ACTIVE));
    lb_addr  = pend_q ? px[9:0] : '0;
    lb_data  = pend_q ? spr_data : '0;
  end

  // Next-state logic; a line_start in any state restarts the scan, flagging overrun if a line was in flight
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    row_d     = row_q;
    col_d     = col_q;
    colw_d    = col_q;
    pend_d    = 1'b0;
    clear_d   = 1'b0;
    y_d       = y_q;
    ox_d      = ox_q;
    oy_d      = oy_q;
    en_d      = en_q;
    overrun_d = overrun_clr ? 1'b0 : overrun_q;
    case (state_q)
      SCAN: begin
        if (hit) begin
          row_d   = RW'(y_ext - oy_ext);
          col_d   = '0;
          state_d = FETCH;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = last ? DONE : SCAN;
        end
      end
      FETCH: begin
        pend_d  = 1'b1;
        col_d   = col_q + CW'(1);
        state_d = (col_q == CW'(SPR_W - 1)) ? DRAIN : FETCH;
      end
      DRAIN: begin
        idx_d   = idx_q + IW'(1);
        state_d = last ? DONE : SCAN;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (line_start) begin
      y_d       = line_y;
      ox_d      = obj_x;
      oy_d      = obj_y;
      en_d      = obj_en;
      idx_d     = '0;
      pend_d    = 1'b0;
      clear_d   = 1'b1;
      state_d   = SCAN;
      overrun_d = busy ? 1'b1 : overrun_d;
    end
  end

  // State and shadow registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      row_q     <= '0;
      col_q     <= '0;
      colw_q    <= '0;
      pend_q    <= 1'b0;
      clear_q   <= 1'b0;
      overrun_q <= 1'b0;
      y_q       <= '0;
      ox_q      <= '0;
      oy_q      <= '0;
      en_q      <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      row_q     <= row_d;
      col_q     <= col_d;
      colw_q    <= colw_d;
      pend_q    <= pend_d;
      clear_q   <= clear_d;
      overrun_q <= overrun_d;
      y_q       <= y_d;
      ox_q      <= ox_d;
      oy_q      <= oy_d;
      en_q      <= en_d;
    end
  end
endmodule

// File: tb/tb_sprite_line_scheduler.sv
// tb_sprite_line_scheduler: directed checks of hit detection, fetch timing, clipping, priority, overrun and reset
module tb_sprite_line_scheduler;
  localparam int N_OBJ = 7;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               line_start = 1'b0;
  logic [9:0]         line_y = '0;
  logic [N_OBJ*10-1:0] obj_x = '0, obj_y = '0;
  logic [N_OBJ-1:0]   obj_en = '0;
  logic [10:0]        spr_addr;
  logic [8:0]         spr_data = '0;
  logic               lb_clear, lb_we, busy, done, overrun;
  logic               overrun_clr = 1'b0;
  logic [9:0]         lb_addr;
  logic [8:0]         lb_data;

  sprite_line_scheduler dut (
    .clk(clk), .rst_n(rst_n), .line_start(line_start), .line_y(line_y),
    .obj_x(obj_x), .obj_y(obj_y), .obj_en(obj_en), .spr_addr(spr_addr), .spr_data(spr_data),
    .lb_clear(lb_clear), .lb_we(lb_we), .lb_addr(lb_addr), .lb_data(lb_data),
    .busy(busy), .done(done), .overrun(overrun), .overrun_clr(overrun_clr)
  );

  always #5 clk = ~clk;

  // Sprite ROM model: every address ending in 5 (mod 8) is transparent
  function automatic logic [8:0] rom(input logic [10:0] a);
    return (a[2:0] == 3'd5) ? 9'h001 : {1'b1, a[7:0]};
  endfunction

  always @(posedge clk) spr_data <= rom(spr_addr);

  int n_checks = 0, n_fail = 0;
  int cyc = 0, we_cnt = 0, bad = 0, done_cnt = 0, done_at = -1, clear_cnt = 0, clear_at = -1;
  int spr_log [0:255];
  logic [8:0] lbuf [0:639];
  bit         wr   [0:639];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // cyc = k during the cycle t+k that follows the line_start edge t
  always @(posedge clk) cyc <= line_start ? 1 : cyc + 1;

  always @(negedge clk) begin
    if (cyc < 256) spr_log[cyc] = int'(spr_addr);
    if (lb_clear) begin
      clear_cnt++;
      clear_at = cyc;
      for (int i = 0; i < 640; i++) wr[i] = 1'b0;
    end
    if (lb_we) begin
      we_cnt++;
      if (lb_clear || lb_addr >= 10'd640) bad++;
      else begin
        lbuf[lb_addr] = lb_data;
        wr[lb_addr]   = 1'b1;
      end
    end
    if (done) begin
      done_cnt++;
      done_at = cyc;
    end
  end

  task automatic set_obj(input int i, input int x, input int y);
    obj_x[i*10 +: 10] = 10'(x);
    obj_y[i*10 +: 10] = 10'(y);
    obj_en[i] = 1'b1;
  endtask

  task automatic start_line(input logic [9:0] y, input bit fresh);
    @(negedge clk);
    if (fresh) begin
      we_cnt = 0; bad = 0; done_cnt = 0; done_at = -1; clear_cnt = 0; clear_at = -1;
    end
    line_y = y;
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
  endtask

  task automatic run_line(input logic [9:0] y);
    start_line(y, 1'b1);
    repeat (300) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_we", lb_we, 0);
    check("rst_clear", lb_clear, 0);
    check("rst_overrun", overrun, 0);
    check("rst_addr", spr_addr, 0);
    rst_n = 1'b1;

    // no objects enabled
    run_line(10'd100);
    check("nohit_clear_at", clear_at, 1);
    check("nohit_clear_cnt", clear_cnt, 1);
    check("nohit_done_at", done_at, 8);
    check("nohit_done_cnt", done_cnt, 1);
    check("nohit_we", we_cnt, 0);

    // car 0 at (200,90), row 10
    set_obj(0, 200, 90);
    run_line(10'd100);
    check("car0_addr_first", spr_log[2], 320);
    check("car0_addr_last", spr_log[33], 351);
    check("car0_we", we_cnt, 28);
    check("car0_done_at", done_at, 41);
    check("car0_px200", lbuf[200], 9'h140);
    check("car0_px205_transp", wr[205], 0);
    check("car0_px231", lbuf[231], 9'h15F);
    check("car0_bad", bad, 0);

    // player over car 1 at the right edge
    obj_en = '0;
    set_obj(1, 620, 40);
    set_obj(6, 630, 50);
    run_line(10'd60);
    check("pri_car1_addr", spr_log[3], 640);
    check("pri_player_addr", spr_log[41], 1344);
    check("pri_we", we_cnt, 27);
    check("pri_bad", bad, 0);
    check("pri_done_at", done_at, 74);
    check("pri_px630", lbuf[630], 9'h140);
    check("pri_px635_car", lbuf[635], 9'h18F);
    check("pri_px625_transp", wr[625], 0);
    check("pri_px639", lbuf[639], 9'h149);

    // boundary rows
    obj_en = '0;
    set_obj(0, 200, 68);
    run_line(10'd100);
    check("y68_done_at", done_at, 8);
    check("y68_we", we_cnt, 0);
    set_obj(0, 200, 69);
    run_line(10'd100);
    check("y69_addr", spr_log[2], 992);
    check("y69_done_at", done_at, 41);
    set_obj(0, 200, 1000);
    run_line(10'd5);
    check("y1000_nohit", done_at, 8);
    run_line(10'd1010);
    check("y1000_hit_addr", spr_log[2], 320);
    check("y1000_hit_done", done_at, 41);

    // overrun: second line_start while busy
    set_obj(0, 200, 90);
    start_line(10'd100, 1'b1);
    repeat (18) @(negedge clk);
    start_line(10'd100, 1'b0);
    check("ovr_set", overrun, 1);
    repeat (300) @(negedge clk);
    check("ovr_clear_cnt", clear_cnt, 2);
    check("ovr_done_cnt", done_cnt, 1);
    check("ovr_done_at", done_at, 41);
    check("ovr_bad", bad, 0);
    check("ovr_sticky", overrun, 1);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    check("ovr_cleared", overrun, 0);

    // asynchronous reset mid-FETCH
    start_line(10'd100, 1'b1);
    repeat (10) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_addr", spr_addr, 0);
    check("arst_we", lb_we, 0);
    check("arst_data", lb_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_line(10'd100);
    check("arst_done_cnt", done_cnt, 1);
    check("arst_done_at", done_at, 41);
    check("arst_we_cnt", we_cnt, 28);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sprite_line_scheduler.md
# sprite_line_scheduler

Sequences the shared sprite ROM for one scanline ahead of the VGA scan-out. On each `line_start` it checks every game object (6 cars, then the raccoon) against the next line and fetches the matching sprite row for each hit. It writes the non-transparent pixels into the back half of an external double-buffered line buffer. It sits between the object position registers and the sprite `ram` instance, and replaces per-pixel address muxing in the renderer.

## Interface
- `N_OBJ`, 7: object count; index N_OBJ-1 is the player, lower indices are cars.
- `SPR_W`, 32: sprite width in pixels, power of two.
- `SPR_H`, 32: sprite height in pixels.
- `H_ACTIVE`, 640: visible width; pixels with x >= H_ACTIVE are clipped.
- `CAR_BASE`, 0: sprite ROM base address for car objects.
- `PLAYER_BASE`, 1024: sprite ROM base address for the player object.
- `TRANSP`, 9'h001: transparent colour code; pixels with this value are never written.
- `clk` in 1: system clock, the only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `line_start` in 1: one-cycle pulse requesting a fetch for `line_y`.
- `line_y` in 10: target line; sampled only on `line_start`.
- `obj_x` in N_OBJ*10: packed X positions; object i is at [10i+9:10i].
- `obj_y` in N_OBJ*10: packed Y positions, same packing as `obj_x`.
- `obj_en` in N_OBJ: per-object enable; a disabled object never hits.
- `spr_addr` out 11: sprite ROM address. The ROM has exactly 1-cycle read latency.
- `spr_data` in 9: sprite ROM data as {R[8:6], G[5:3], B[2:0]}.
- `lb_clear` out 1: one-cycle pulse that flash-clears the back-buffer valid bits.
- `lb_we` out 1: back-buffer write strobe.
- `lb_addr` out 10: back-buffer pixel X.
- `lb_data` out 9: back-buffer pixel colour.
- `busy` out 1: high from the cycle after `line_start` until `done`.
- `done` out 1: one-cycle pulse when the line is complete; the external logic swaps buffers on it.
- `overrun` out 1: sticky error flag.
- `overrun_clr` in 1: clears `overrun`.

## Operation
- States: IDLE, SCAN, FETCH, DRAIN, DONE.
- Reset value of every output and internal register is 0; the FSM resets to IDLE.
- IDLE:
  - On `line_start`, latch `line_y` and all `obj_x`, `obj_y`, `obj_en` into shadow registers.
  - Set i=0 and go to SCAN.
  - Later changes to the position inputs do not affect the line in progress.
- SCAN (one cycle per object):
  - Hit = `obj_en`[i] && y >= oy && y < oy+SPR_H, evaluated in 11 bits so that oy+SPR_H cannot wrap.
  - On a hit: row = y-oy, col = 0, go to FETCH.
  - On a miss: i++; if i was N_OBJ-1, go to DONE.
- FETCH:
  - `spr_addr` = base + row*SPR_W + col, where base = PLAYER_BASE if i==N_OBJ-1, else CAR_BASE.
  - col increments every cycle.
  - After issuing col=SPR_W-1, go to DRAIN.
- DRAIN: one cycle to receive the last data word. Then i++ and go to SCAN, or go to DONE if i was N_OBJ-1.
- Write pipeline:
  - The data for the address issued in cycle c arrives in cycle c+1.
  - In cycle c+1: `lb_we` = (`spr_data` != TRANSP) && (ox+col_d < H_ACTIVE), where col_d is the column issued in cycle c.
  - `lb_addr` = (ox+col_d)[9:0], computed in 11 bits for the clip test. `lb_data` = `spr_data`.
- Priority: objects are drawn in index order, so a later index overwrites an earlier one and the player is always on top.
- DONE: `done`=1 for one cycle and `busy`=0, then go to IDLE.
- `line_start` while `busy`:
  - Abort the line in progress and set `overrun`=1.
  - Re-latch the inputs and restart at SCAN i=0, with a fresh `lb_clear`.
- `line_start` during the DONE cycle: the fetch starts normally and `overrun` is not set.
- `overrun_clr` and a new overrun in the same cycle: the set wins.

## Timing
- Cycle numbering: `line_start` is sampled high at edge t.
- Cycle t+1:
  - `busy`=1 and `lb_clear`=1 (the clear pulse lasts exactly one cycle).
  - This is the first SCAN cycle.
- Total time from t to the `done` pulse is N_OBJ + k*(SPR_W+1) + 1 cycles, with k = number of hits.
  - With defaults and all 7 objects hit: 239 cycles, well under the 800-cycle line period.
- Per hit: SPR_W address cycles, then SPR_W write-capable cycles offset by one. The DRAIN cycle carries the last write.
- `lb_we` is never asserted in IDLE or DONE, or during the `lb_clear` cycle.
- Asynchronous reset mid-line returns the FSM to IDLE immediately, with all outputs 0. No `done` is produced for the aborted line.

## Test plan
- No hits (all `obj_en`=0), `line_start` with `line_y`=100:
  - `lb_clear` at t+1.
  - `done` at t+8.
  - No `lb_we`.
- Car 0 at (200,90), `line_y`=100:
  - `spr_addr` = 320..351.
  - 32 writes with `lb_addr` = 200..231, minus TRANSP pixels.
  - `done` at t+41.
- Player at (630,50) and car 1 at (620,40), `line_y`=60:
  - Player writes at x=630..639 overwrite car 1 at the same addresses, since the player is drawn last.
  - Writes with x >= 640 are suppressed.
  - Player addresses start at 1024+10*32.
- Boundary rows:
  - Object at y=68, `line_y`=100: hit, row 32-... row 32 is out of range, so no hit at oy+SPR_H = 100 exactly.
  - Object at y=69, `line_y`=100: hit with row 31.
  - Object at y=1000 (oy+SPR_H > 1023): no wrap, no false hit.
- Second `line_start` 20 cycles after the first:
  - `overrun`=1 and a second `lb_clear` pulse.
  - A single `done`, for the second line.
  - `overrun_clr` then returns `overrun` to 0.
- Assert `rst_n`=0 mid-FETCH:
  - All outputs go to 0 asynchronously.
  - After release, `line_start` completes normally.
